bram_heap_pq: RTL
=================

# bram_heap_pq

Parametrised BRAM-backed binary-heap priority queue; successor to the fixed-width `bram_tree`. Generalises depth and key width, adds a per-entry payload, selectable max/min ordering, and true enqueue with sift-up. It also adds an explicit ready handshake, so callers no longer rely on fixed wait counts. It sits between a scheduler front-end and its consumers and exposes the current best entry combinationally from a root shadow register.

## Interface
- `QUEUE_SIZE`, 15: maximum number of entries (≥2).
- `KEY_WIDTH`, 16: priority key width.
- `PAYLOAD_WIDTH`, 8: payload carried with each key.
- `MAX_HEAP`, 1: 1 = largest key at root; 0 = smallest key at root.
- Derived: `LEVELS = $clog2(QUEUE_SIZE+1)`, `AW = $clog2(QUEUE_SIZE)`.
- Clocking and reset: one clock; reset is asynchronous and active-high.
- `CLK` in 1: clock; all state changes on the rising edge.
- `RST` in 1: asynchronous, active-high reset.
- `i_wrt` in 1: write request; see the operation decode.
- `i_read` in 1: read request; see the operation decode.
- `i_key` in KEY_WIDTH: key for enqueue and replace.
- `i_payload` in PAYLOAD_WIDTH: payload for enqueue and replace.
- `o_ready` out 1: idle; a request is accepted on this cycle.
- `o_full` out 1: `o_size == QUEUE_SIZE`.
- `o_empty` out 1: `o_size == 0`.
- `o_key` out KEY_WIDTH: root key; 0 when empty.
- `o_payload` out PAYLOAD_WIDTH: root payload; 0 when empty.
- `o_size` out AW+1: current entry count.

## Operation
- Acceptance: a request is accepted when `o_ready` is high and `i_wrt|i_read` is high at a rising edge.
- Operation decode:
  - `i_wrt` only = ENQ.
  - `i_read` only = DEQ.
  - both = REP (pop root and insert the new entry).
- Ignored requests: ENQ while full and DEQ while empty are ignored; `o_ready` stays high and no state changes.
- REP while empty behaves as ENQ.
- Storage: dual-port RAM indexed 0..QUEUE_SIZE-1. Children of i are 2i+1 and 2i+2; the parent of i is (i-1)>>1.
- "Hole" method: the moving entry is held in a register `mov`; each level does a single RAM write, with no swap pairs.
- Priority comparison: A beats B iff `A.key > B.key` (MAX_HEAP=1) or `A.key < B.key` (MAX_HEAP=0). Ties never move an entry. Between equal children, the left child wins.
- ENQ:
  - `mov` = input; hole = `o_size`; size+1.
  - Loop: if hole==0, or the parent does not lose to `mov`, write `mov` at the hole and finish.
  - Otherwise write the parent into the hole; hole = parent.
- DEQ:
  - size-1; `mov` = entry[old size-1]; hole = 0.
  - If the new size is 0, finish immediately with the root cleared.
- REP: `mov` = input; hole = 0; size unchanged.
- Sift-down (DEQ and REP):
  - Read both children in the same cycle; only indices < size are valid.
  - If there is no valid child, or the best child does not beat `mov`, write `mov` at the hole and finish.
  - Otherwise write the best child into the hole; hole = best child.
- Root shadow: any write to index 0 also loads `o_key`/`o_payload`. Reaching size 0 clears both to 0.
- FSM states:
  - `IDLE`: `o_ready`=1.
  - `FETCH`: DEQ only; read the last entry.
  - `UP_RD` → `UP_WR`: loop back to `UP_RD` or go to `IDLE`.
  - `DN_RD` → `DN_WR`: loop back to `DN_RD` or go to `IDLE`.

## Timing
- Reset values: `o_ready`=1, `o_empty`=1, `o_full`=0, `o_key`=0, `o_payload`=0, `o_size`=0, FSM=`IDLE`. RAM contents are not reset and are don't-care.
- RAM read latency is 1 cycle, so each level costs 2 cycles (RD, WR).
- `o_size`, `o_full` and `o_empty` update on the edge that accepts the request.
- `o_ready` deasserts the cycle after acceptance. It reasserts within 2·LEVELS+2 cycles (ENQ/REP) or 2·LEVELS+3 cycles (DEQ).
- `o_key`/`o_payload` are stable and correct whenever `o_ready`=1. They are undefined while busy unless empty.
- Back-to-back: a new request may be accepted on the first cycle `o_ready` is high again.
- Requests presented while `o_ready`=0 are dropped, not queued.
- `RST` asserted mid-operation aborts the sift immediately and returns all outputs to their reset values (queue empty).

## Structure
- Package `bram_heap_pkg`: `state_t` enum (`IDLE`, `FETCH`, `UP_RD`, `UP_WR`, `DN_RD`, `DN_WR`) and `op_t` enum (`OP_ENQ`, `OP_DEQ`, `OP_REP`).
- Entry width is parameter-dependent, so it is packed locally as `{key,payload}`.
- Sub-module: `bram_heap_tdp_ram` — true dual-port, 1-cycle synchronous read, write-first on port A, depth QUEUE_SIZE. Instance name `bram_inst`.

## Test plan
Bench settings: QUEUE_SIZE=7, KEY_WIDTH=16, PAYLOAD_WIDTH=8, MAX_HEAP=1 unless noted. The bench waits on `o_ready`, never on fixed counts.
- Reset: pulse `RST` → `o_ready`=1, `o_empty`=1, `o_full`=0, `o_size`=0, `o_key`=0. ENQ 5 issued immediately after release → accepted, `o_key`=5.
- Enqueue order: ENQ 5, 9, 3, 7 → `o_key`=9, `o_size`=4. Each op is ready within 8 cycles.
- Full: ENQ 1, 2, 8 (size 7) → `o_full`=1. A further ENQ 100 is ignored: `o_size`=7, `o_key`=9. DEQ ×7 returns 9, 8, 7, 5, 3, 2, 1. A further DEQ is ignored, `o_key`=0, `o_empty`=1.
- Replace: heap {9, 7, 5}, REP 6 → `o_key`=7, `o_size`=3. Then DEQ returns 7, 6, 5.
- Min mode with payloads (MAX_HEAP=0): ENQ (4, 0xA1), (4, 0xB2), (2, 0xC3) → root (2, 0xC3). After DEQ, root is (4, 0xA1), since ties do not move.
- Mid-op reset: during a 3-level REP, assert `RST` for 1 cycle → outputs return to reset values and the next ENQ 11 gives `o_key`=11, `o_size`=1.

Source files
------------

// File: rtl/bram_heap_pkg.sv
// Shared types for the BRAM-backed heap priority queue.
//   state_t : sequencer states (idle, last-entry fetch, sift-up and sift-down read/write)
//   op_t    : decoded request kind
package bram_heap_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    UP_RD,
    UP_WR,
    DN_RD,
    DN_WR
  } state_t;

  typedef enum logic [1:0] {
    OP_ENQ,
    OP_DEQ,
    OP_REP
  } op_t;

endpackage

// File: rtl/bram_heap_tdp_ram.sv
// True dual-port RAM with 1-cycle synchronous read; port A is write-first.
// Contents are not reset.
//   clk                        : clock
//   a_en/a_we/a_addr/a_wdata   : port A enable, write enable, address, write data
//   a_rdata                    : port A registered read data
//   b_en/b_we/b_addr/b_wdata   : port B enable, write enable, address, write data
//   b_rdata                    : port B registered read data
module bram_heap_tdp_ram #(
  parameter int DEPTH = 15,
  parameter int AW    = 4,
  parameter int DW    = 24
) (
  input  logic          clk,
  input  logic          a_en,
  input  logic          a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic [DW-1:0] a_rdata,
  input  logic          b_en,
  input  logic          b_we,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic [DW-1:0] b_rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (a_en) begin
      if (a_we) begin
        mem[a_addr] <= a_wdata;
        a_rdata     <= a_wdata;
      end else begin
        a_rdata <= mem[a_addr];
      end
    end
    if (b_en) begin
      if (b_we) begin
        mem[b_addr] <= b_wdata;
      end
      b_rdata <= mem[b_addr];
    end
  end

endmodule

// File: rtl/bram_heap_pq.sv
// Binary-heap priority queue stored in a dual-port BRAM, root mirrored in a
// shadow register so the best entry is visible without a RAM read.
//   CLK, RST            : clock, asynchronous active-high reset
//   i_wrt, i_read       : request (wrt=enqueue, read=dequeue, both=replace root)
//   i_key, i_payload    : entry for enqueue/replace
//   o_ready             : idle, request accepted this cycle
//   o_full, o_empty     : occupancy flags
//   o_key, o_payload    : current root (0 when empty)
//   o_size              : entry count
module bram_heap_pq
  import bram_heap_pkg::*;
#(
  parameter int QUEUE_SIZE    = 15,
  parameter int KEY_WIDTH     = 16,
  parameter int PAYLOAD_WIDTH = 8,
  parameter int MAX_HEAP      = 1
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         i_wrt,
  input  logic                         i_read,
  input  logic [KEY_WIDTH-1:0]         i_key,
  input  logic [PAYLOAD_WIDTH-1:0]     i_payload,
  output logic                         o_ready,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [KEY_WIDTH-1:0]         o_key,
  output logic [PAYLOAD_WIDTH-1:0]     o_payload,
  output logic [$clog2(QUEUE_SIZE):0]  o_size
);

  localparam int AW = $clog2(QUEUE_SIZE);
  localparam int EW = KEY_WIDTH + PAYLOAD_WIDTH;
  localparam int IW = AW + 2;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(QUEUE_SIZE);

  state_t        state_q, state_d;
  logic [AW:0]   size_q, size_d;
  logic [AW-1:0] hole_q, hole_d;
  logic [EW-1:0] mov_q, mov_d;
  logic [EW-1:0] root_q, root_d;
  logic          fetch_q, fetch_d;

  logic          a_en, a_we, b_en;
  logic [AW-1:0] a_addr, b_addr;
  logic [EW-1:0] a_wdata, a_rdata, b_rdata;

  op_t           op;
  logic [IW-1:0] left_idx, right_idx, size_ext;
  logic          l_valid, r_valid, r_better;
  logic [EW-1:0] best_data;
  logic [AW-1:0] best_idx, parent_idx;

  function automatic logic [KEY_WIDTH-1:0] key_of(input logic [EW-1:0] e);
    return e[EW-1:PAYLOAD_WIDTH];
  endfunction

  // Strict: equal keys never beat each other, so ties never move an entry.
  function automatic logic beats(input logic [KEY_WIDTH-1:0] a,
                                 input logic [KEY_WIDTH-1:0] b);
    if (MAX_HEAP != 0) return a > b;
    else               return a < b;
  endfunction

  bram_heap_tdp_ram #(
    .DEPTH (QUEUE_SIZE),
    .AW    (AW),
    .DW    (EW)
  ) bram_inst (
    .clk     (CLK),
    .a_en    (a_en),
    .a_we    (a_we),
    .a_addr  (a_addr),
    .a_wdata (a_wdata),
    .a_rdata (a_rdata),
    .b_en    (b_en),
    .b_we    (1'b0),
    .b_addr  (b_addr),
    .b_wdata ('0),
    .b_rdata (b_rdata)
  );

  always_comb begin
    if (i_wrt && i_read) op = OP_REP;
    else if (i_wrt)      op = OP_ENQ;
    else                 op = OP_DEQ;

    left_idx   = {1'b0, hole_q, 1'b1};
    right_idx  = left_idx + IW'(1);
    size_ext   = {1'b0, size_q};
    l_valid    = left_idx < size_ext;
    r_valid    = right_idx < size_ext;
    // Left child wins ties between siblings.
    r_better   = r_valid && beats(key_of(b_rdata), key_of(a_rdata));
    best_data  = r_better ? b_rdata : a_rdata;
    best_idx   = r_better ? right_idx[AW-1:0] : left_idx[AW-1:0];
    parent_idx = (hole_q - AW'(1)) >> 1;

    state_d = state_q;
    size_d  = size_q;
    hole_d  = hole_q;
    mov_d   = mov_q;
    root_d  = root_q;
    fetch_d = fetch_q;
    a_en    = 1'b0;
    a_we    = 1'b0;
    a_addr  = '0;
    a_wdata = mov_q;
    b_en    = 1'b0;
    b_addr  = '0;

    case (state_q)
      IDLE: begin
        if (i_wrt || i_read) begin
          case (op)
            OP_DEQ: begin
              if (size_q != '0) begin
                size_d = size_q - (AW+1)'(1);
                hole_d = '0;
                if (size_q == (AW+1)'(1)) root_d = '0;
                else                      state_d = FETCH;
              end
            end
            default: begin
              if (op == OP_REP && size_q != '0) begin
                mov_d   = {i_key, i_payload};
                hole_d  = '0;
                fetch_d = 1'b0;
                state_d = DN_RD;
              end else if (size_q != FULL_CNT) begin
                // Enqueue, or replace on an empty queue.
                mov_d   = {i_key, i_payload};
                hole_d  = size_q[AW-1:0];
                size_d  = size_q + (AW+1)'(1);
                state_d = UP_RD;
              end
            end
          endcase
        end
      end
      FETCH: begin
        // size_q already holds the decremented count, i.e. the last index.
        a_en    = 1'b1;
        a_addr  = size_q[AW-1:0];
        fetch_d = 1'b1;
        state_d = DN_RD;
      end
      UP_RD: begin
        a_en = 1'b1;
        if (hole_q == '0) begin
          a_we    = 1'b1;
          state_d = IDLE;
        end else begin
          a_addr  = parent_idx;
          state_d = UP_WR;
        end
      end
      UP_WR: begin
        a_en   = 1'b1;
        a_we   = 1'b1;
        a_addr = hole_q;
        if (beats(key_of(mov_q), key_of(a_rdata))) begin
          a_wdata = a_rdata;
          hole_d  = parent_idx;
          state_d = UP_RD;
        end else begin
          state_d = IDLE;
        end
      end
      DN_RD: begin
        // Port A still holds the last entry read during FETCH.
        if (fetch_q) mov_d = a_rdata;
        fetch_d = 1'b0;
        a_en    = l_valid;
        a_addr  = l_valid ? left_idx[AW-1:0] : '0;
        b_en    = r_valid;
        b_addr  = r_valid ? right_idx[AW-1:0] : '0;
        state_d = DN_WR;
      end
      DN_WR: begin
        a_en   = 1'b1;
        a_we   = 1'b1;
        a_addr = hole_q;
        if (l_valid && beats(key_of(best_data), key_of(mov_q))) begin
          a_wdata = best_data;
          hole_d  = best_idx;
          state_d = DN_RD;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (a_we && a_addr == '0) root_d = a_wdata;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      size_q  <= '0;
      hole_q  <= '0;
      mov_q   <= '0;
      root_q  <= '0;
      fetch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      size_q  <= size_d;
      hole_q  <= hole_d;
      mov_q   <= mov_d;
      root_q  <= root_d;
      fetch_q <= fetch_d;
    end
  end

  assign o_ready   = (state_q == IDLE);
  assign o_full    = (size_q == FULL_CNT);
  assign o_empty   = (size_q == '0);
  assign o_size    = size_q;
  assign o_key     = root_q[EW-1:PAYLOAD_WIDTH];
  assign o_payload = root_q[PAYLOAD_WIDTH-1:0];

endmodule
